dmem_bridge: RTL

- Sits directly downstream of the single-cycle datapath, on its data-memory port.
- Takes the datapath's ALU result (the address), its write data and the memread/memwrite strobes, and runs a valid/ready transaction on the external data bus.
- Asserts stall to freeze the PC register and the register-file write enable until the access completes.
- Returns the read data as the datapath's readdata input.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/timeout_counter.sv | 29 ++
 rtl/dmem_bridge.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory bridge: FSM states, error causes and
// the debug view exported by the top level.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_t;

  typedef struct packed {
    state_t     state;
    err_cause_t cause;
  } dbg_t;

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter for bus-wait cycles; tc rises on the TIMEOUT-th enabled cycle
// after the last clear and then holds until cleared again.
module timeout_counter #(
  parameter int TIMEOUT = mem_pkg::DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign tc = (count >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle datapath's data-memory port onto a valid/ready bus,
// stalling the datapath until each load or store completes.
//
// Handshake: a request transfers on the rising edge where bus_valid and
// bus_ready are both high; bus_valid, bus_we, bus_addr and bus_wdata are held
// stable from assertion until that edge. A read response transfers on any
// rising edge in RESP where bus_rvalid is high; rvalid outside RESP is ignored.
module dmem_bridge
  import mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          err,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  output dbg_t          dbg
);

  state_t     state, state_nxt;
  err_cause_t cause;
  logic       access, misaligned, handshake, timed_out;

  assign access     = memread | memwrite;
  assign misaligned = (addr[1:0] != 2'b00);
  assign handshake  = bus_valid & bus_ready;
  assign dbg        = '{state: state, cause: cause};

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state == REQ) || (state == RESP)),
    .tc     (timed_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stall is gated by reset so a held strobe cannot freeze the datapath in reset.
  always_comb begin
    state_nxt = state;
    bus_valid = 1'b0;
    stall     = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        stall = access & reset;
        if (access) state_nxt = misaligned ? DONE : REQ;
      end
      REQ: begin
        bus_valid = 1'b1;
        stall     = 1'b1;
        if (handshake)      state_nxt = bus_we ? DONE : RESP;
        else if (timed_out) state_nxt = DONE;
      end
      RESP: begin
        stall = 1'b1;
        if (bus_rvalid || timed_out) state_nxt = DONE;
      end
      DONE: begin
        err       = (cause != ERR_NONE);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      cause     <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (access && misaligned) begin
            cause <= ERR_ALIGN;
            rdata <= '0;
          end else if (access) begin
            cause     <= ERR_NONE;
            bus_addr  <= addr;
            bus_wdata <= wdata;
            bus_we    <= memwrite;
          end
        end
        REQ: begin
          if (!handshake && timed_out) begin
            cause <= ERR_TIMEOUT;
            rdata <= '0;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            rdata <= bus_rdata;
          end else if (timed_out) begin
            cause <= ERR_TIMEOUT;
            rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
